// File: rtl/loop_ctrl_pkg.sv
// rtl/loop_ctrl_pkg.sv - shared state encoding and default sizing for the gate sequencer
package loop_ctrl_pkg;

    localparam int DT_W_DEF    = 6;
    localparam int TMO_W_DEF   = 8;
    localparam int TMO_MAX_DEF = 200;
    localparam int MIN_ON_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LS_ON = 3'd1,
        ST_DTLH  = 3'd2,
        ST_HS_ON = 3'd3,
        ST_DTHL  = 3'd4,
        ST_FLT   = 3'd5
    } state_e;

endpackage

// File: rtl/sync2_loop_control.sv
// rtl/sync2_loop_control.sv - two-flop synchroniser with selectable reset value
module sync2_loop_control #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gate_seq_loop_control.sv
// rtl/gate_seq_loop_control.sv - break-before-make high/low-side gate sequencer
module gate_seq_loop_control
    import loop_ctrl_pkg::*;
#(
    parameter int DT_W    = DT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF,
    parameter int MIN_ON  = MIN_ON_DEF
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            SUB,
    input  logic            EN,
    input  logic            PWM_REQ,
    input  logic            FAULT_IN,
    input  logic            HS_OFF_FB,
    input  logic            LS_OFF_FB,
    input  logic [DT_W-1:0] DT_HL,
    input  logic [DT_W-1:0] DT_LH,
    output logic            HS_EN,
    output logic            LS_EN,
    output logic            FAULT,
    output logic [2:0]      STATE
);

    localparam int ON_W = $clog2(MIN_ON + 1);
    localparam logic [ON_W-1:0] ON_ONE = ON_W'(1);
    localparam logic [ON_W-1:0] ON_MIN = ON_W'(MIN_ON);

    logic w_pwm_s;
    logic w_fault_s;
    logic w_hs_fb_s;
    logic w_ls_fb_s;
    logic w_unused_supply;

    assign w_unused_supply = CELV & CELG & SUB;

    sync2_loop_control #(.RST_VAL(1'b0)) u_sync_pwm (
        .i_clk(CLK), .i_rstn(RSTN), .i_d(PWM_REQ), .o_q(w_pwm_s)
    );
    sync2_loop_control #(.RST_VAL(1'b0)) u_sync_fault (
        .i_clk(CLK), .i_rstn(RSTN), .i_d(FAULT_IN), .o_q(w_fault_s)
    );
    // Feedback resets to "gate off" so the first dead time after reset is not stalled
    sync2_loop_control #(.RST_VAL(1'b1)) u_sync_hs_fb (
        .i_clk(CLK), .i_rstn(RSTN), .i_d(HS_OFF_FB), .o_q(w_hs_fb_s)
    );
    sync2_loop_control #(.RST_VAL(1'b1)) u_sync_ls_fb (
        .i_clk(CLK), .i_rstn(RSTN), .i_d(LS_OFF_FB), .o_q(w_ls_fb_s)
    );

    state_e            r_state;
    logic              r_hs_en;
    logic              r_ls_en;
    logic              r_fault;
    logic [TMO_W-1:0]  r_cnt;
    logic [DT_W-1:0]   r_dt;
    logic [ON_W-1:0]   r_on;

    logic [TMO_W:0]    w_cnt_inc;
    logic [TMO_W:0]    w_dt_ext;
    logic              w_dt_done;
    logic              w_tmo;
    logic              w_on_sat;
    logic [ON_W-1:0]   w_on_nxt;

    // Dead time is done once the cycle being completed is number r_dt; DT=0 behaves as DT=1
    assign w_cnt_inc = {1'b0, r_cnt} + {{TMO_W{1'b0}}, 1'b1};
    assign w_dt_ext  = {{(TMO_W + 1 - DT_W){1'b0}}, r_dt};
    assign w_dt_done = (w_cnt_inc >= w_dt_ext);
    assign w_tmo     = (w_cnt_inc == (TMO_W + 1)'(TMO_MAX));
    assign w_on_sat  = (r_on >= ON_MIN);
    assign w_on_nxt  = w_on_sat ? r_on : r_on + ON_ONE;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_hs_en <= 1'b0;
            r_ls_en <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_dt    <= '0;
            r_on    <= '0;
        end else if (!EN) begin
            r_state <= ST_IDLE;
            r_hs_en <= 1'b0;
            r_ls_en <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_on    <= '0;
        end else if (w_fault_s && (r_state != ST_IDLE)) begin
            r_state <= ST_FLT;
            r_hs_en <= 1'b0;
            r_ls_en <= 1'b0;
            r_fault <= 1'b1;
            r_cnt   <= '0;
            r_on    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pwm_s) begin
                        r_state <= ST_DTLH;
                        r_cnt   <= '0;
                        r_dt    <= DT_LH;
                    end else begin
                        r_state <= ST_LS_ON;
                        r_ls_en <= 1'b1;
                        r_on    <= ON_ONE;
                    end
                end
                ST_LS_ON: begin
                    if (w_pwm_s && w_on_sat) begin
                        r_state <= ST_DTLH;
                        r_ls_en <= 1'b0;
                        r_cnt   <= '0;
                        r_dt    <= DT_LH;
                    end else begin
                        r_on    <= w_on_nxt;
                    end
                end
                ST_DTLH: begin
                    if (w_tmo) begin
                        r_state <= ST_FLT;
                        r_fault <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_dt_done && w_ls_fb_s) begin
                        r_state <= ST_HS_ON;
                        r_hs_en <= 1'b1;
                        r_on    <= ON_ONE;
                    end else begin
                        r_cnt   <= w_cnt_inc[TMO_W-1:0];
                    end
                end
                ST_HS_ON: begin
                    if (!w_pwm_s && w_on_sat) begin
                        r_state <= ST_DTHL;
                        r_hs_en <= 1'b0;
                        r_cnt   <= '0;
                        r_dt    <= DT_HL;
                    end else begin
                        r_on    <= w_on_nxt;
                    end
                end
                ST_DTHL: begin
                    if (w_tmo) begin
                        r_state <= ST_FLT;
                        r_fault <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_dt_done && w_hs_fb_s) begin
                        r_state <= ST_LS_ON;
                        r_ls_en <= 1'b1;
                        r_on    <= ON_ONE;
                    end else begin
                        r_cnt   <= w_cnt_inc[TMO_W-1:0];
                    end
                end
                ST_FLT: begin
                    r_hs_en <= 1'b0;
                    r_ls_en <= 1'b0;
                    r_fault <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hs_en <= 1'b0;
                    r_ls_en <= 1'b0;
                end
            endcase
        end
    end

    assign HS_EN = r_hs_en;
    assign LS_EN = r_ls_en;
    assign FAULT = r_fault;
    assign STATE = r_state;

endmodule

// File: tb/tb_gate_seq_loop_control.sv
// tb/tb_gate_seq_loop_control.sv - self-checking bench for gate_seq_loop_control
module tb_gate_seq_loop_control;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       CELV;
    logic       CELG;
    logic       SUB;
    logic       EN;
    logic       PWM_REQ;
    logic       FAULT_IN;
    logic       HS_OFF_FB;
    logic       LS_OFF_FB;
    logic [5:0] DT_HL;
    logic [5:0] DT_LH;
    logic       HS_EN;
    logic       LS_EN;
    logic       FAULT;
    logic [2:0] STATE;

    gate_seq_loop_control dut (
        .CLK(CLK), .RSTN(RSTN), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .EN(EN), .PWM_REQ(PWM_REQ), .FAULT_IN(FAULT_IN),
        .HS_OFF_FB(HS_OFF_FB), .LS_OFF_FB(LS_OFF_FB),
        .DT_HL(DT_HL), .DT_LH(DT_LH),
        .HS_EN(HS_EN), .LS_EN(LS_EN), .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int total   = 0;
    int bad     = 0;
    int overlap = 0;

    typedef struct {
        bit to_hs;
        int dt;
        int dt_after;
        int exp_lat;
        int exp_gap;
    } vec_t;

    typedef struct {
        int lat;
        int gap;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    always @(negedge CLK) begin
        if (HS_EN === 1'b1 && LS_EN === 1'b1) overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic sig(input int w);
        if (w == 0) return HS_EN;
        if (w == 1) return LS_EN;
        return FAULT;
    endfunction

    task automatic wait_lvl(input string name, input int w, input logic val, input int limit);
        int n = 0;
        while (sig(w) !== val && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(sig(w)), int'(val));
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat = 0;
        int   gap = 0;
        e.lat = v.exp_lat;
        e.gap = v.exp_gap;
        if (v.to_hs) DT_LH = 6'(v.dt);
        else         DT_HL = 6'(v.dt);
        PWM_REQ = v.to_hs;
        sb.push_back(e);
        while (sig(v.to_hs ? 1 : 0) === 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (v.to_hs) DT_LH = 6'(v.dt_after);
        else         DT_HL = 6'(v.dt_after);
        while (sig(v.to_hs ? 0 : 1) !== 1'b1 && gap < 300) begin
            tick();
            gap++;
        end
        got = sb.pop_front();
        check($sformatf("vec dt=%0d fall_latency", v.dt), lat, got.lat);
        check($sformatf("vec dt=%0d dead_gap", v.dt), gap, got.gap);
        repeat (6) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b1,  5,  5, 3,  5};
        vecs[1] = '{1'b0,  3,  3, 3,  3};
        vecs[2] = '{1'b1,  0,  0, 3,  1};
        vecs[3] = '{1'b0,  1,  1, 3,  1};
        vecs[4] = '{1'b1,  2, 40, 3,  2};
        vecs[5] = '{1'b0, 63, 63, 3, 63};
        vecs[6] = '{1'b1, 10,  0, 3, 10};
        vecs[7] = '{1'b0,  2,  2, 3,  2};

        RSTN = 1'b0; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
        EN = 1'b0; PWM_REQ = 1'b0; FAULT_IN = 1'b0;
        HS_OFF_FB = 1'b1; LS_OFF_FB = 1'b1;
        DT_HL = 6'd3; DT_LH = 6'd5;
        repeat (3) tick();
        check("reset HS_EN", int'(HS_EN), 0);
        check("reset LS_EN", int'(LS_EN), 0);
        check("reset FAULT", int'(FAULT), 0);
        check("reset STATE", int'(STATE), 0);
        RSTN = 1'b1;
        repeat (2) tick();
        check("idle with EN=0", int'(STATE), 0);

        EN = 1'b1;
        n = 0;
        while (LS_EN !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("ls_on latency within 3", int'(n >= 1 && n <= 3), 1);
        check("hs off at start", int'(HS_EN), 0);
        repeat (6) tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Low-side entry waits on late high-side off confirmation
        DT_LH = 6'd2;
        PWM_REQ = 1'b1;
        wait_lvl("to hs_on", 0, 1'b1, 20);
        repeat (6) tick();
        HS_OFF_FB = 1'b0;
        DT_HL = 6'd3;
        PWM_REQ = 1'b0;
        wait_lvl("hs fall", 0, 1'b0, 20);
        n = 0;
        repeat (10) begin
            tick();
            if (LS_EN !== 1'b0) n++;
        end
        check("ls held off while fb low", n, 0);
        HS_OFF_FB = 1'b1;
        tick(); tick();
        check("ls off before fb synced", int'(LS_EN), 0);
        tick();
        check("ls on after fb synced", int'(LS_EN), 1);
        repeat (6) tick();

        // Feedback stuck: timeout into FLT, then EN re-arm
        PWM_REQ = 1'b1;
        wait_lvl("to hs_on 2", 0, 1'b1, 20);
        repeat (6) tick();
        HS_OFF_FB = 1'b0;
        PWM_REQ = 1'b0;
        wait_lvl("hs fall 2", 0, 1'b0, 20);
        n = 0;
        while (FAULT !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("timeout cycles", n, 200);
        check("timeout STATE", int'(STATE), 5);
        check("timeout HS_EN", int'(HS_EN), 0);
        check("timeout LS_EN", int'(LS_EN), 0);
        EN = 1'b0;
        tick();
        check("rearm FAULT", int'(FAULT), 0);
        check("rearm STATE", int'(STATE), 0);
        HS_OFF_FB = 1'b1;
        EN = 1'b1;
        wait_lvl("back to ls_on", 1, 1'b1, 10);
        repeat (6) tick();

        // Short low pulse right after HS_ON entry is swallowed by MIN_ON
        LS_OFF_FB = 1'b0;
        PWM_REQ = 1'b1;
        wait_lvl("ls fall 3", 1, 1'b0, 20);
        repeat (4) tick();
        LS_OFF_FB = 1'b1;
        PWM_REQ = 1'b0;
        tick(); tick();
        PWM_REQ = 1'b1;
        tick();
        check("hs entry", int'(HS_EN), 1);
        n = 0;
        repeat (10) begin
            tick();
            if (HS_EN !== 1'b1) n++;
        end
        check("hs held through pulse", n, 0);
        check("state hs_on after pulse", int'(STATE), 3);

        // Held request is served exactly when MIN_ON expires
        PWM_REQ = 1'b0;
        wait_lvl("to ls_on 4", 1, 1'b1, 20);
        repeat (6) tick();
        LS_OFF_FB = 1'b0;
        PWM_REQ = 1'b1;
        wait_lvl("ls fall 4", 1, 1'b0, 20);
        repeat (4) tick();
        LS_OFF_FB = 1'b1;
        PWM_REQ = 1'b0;
        wait_lvl("hs rise 4", 0, 1'b1, 10);
        n = 0;
        while (HS_EN === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("hs on time equals MIN_ON", n, 4);
        wait_lvl("to ls_on 5", 1, 1'b1, 20);
        repeat (6) tick();

        // External fault while in DTLH
        LS_OFF_FB = 1'b0;
        PWM_REQ = 1'b1;
        wait_lvl("ls fall 5", 1, 1'b0, 20);
        check("in dtlh", int'(STATE), 2);
        FAULT_IN = 1'b1;
        repeat (3) tick();
        check("fault_in FAULT", int'(FAULT), 1);
        check("fault_in STATE", int'(STATE), 5);
        EN = 1'b0;
        FAULT_IN = 1'b0;
        LS_OFF_FB = 1'b1;
        tick();
        check("fault clear", int'(FAULT), 0);

        // Async reset drops HS_EN without waiting for a clock
        EN = 1'b1;
        wait_lvl("hs on before reset", 0, 1'b1, 30);
        RSTN = 1'b0;
        #1;
        check("async reset HS_EN", int'(HS_EN), 0);
        check("async reset STATE", int'(STATE), 0);
        tick();
        RSTN = 1'b1;

        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 7) == 0) PWM_REQ = ~PWM_REQ;
            HS_OFF_FB = ($urandom_range(0, 3) != 0);
            LS_OFF_FB = ($urandom_range(0, 3) != 0);
            DT_HL = 6'($urandom_range(0, 7));
            DT_LH = 6'($urandom_range(0, 7));
            FAULT_IN = ($urandom_range(0, 499) == 0);
            EN = ($urandom_range(0, 299) != 0);
            tick();
        end
        check("no HS/LS overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
